// File: rtl/mem_bridge_pkg.sv
// Shared encodings for mem_bridge: sequencer states and read-source select.
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

endpackage

// File: rtl/mem_bridge.sv
// Arbitrates core fetch / data-read / data-write onto one single-port SRAM
// with fixed read latency; returns registered data with a one-cycle ack.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int IADDR_W = 64,
    parameter int RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_req_i,
    input  logic [IADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0]  inst_o,
    output logic               inst_ack_o,
    input  logic               mem_r_req_i,
    input  logic [ADDR_W-1:0]  mem_r_addr_i,
    output logic [DATA_W-1:0]  mem_r_data_o,
    output logic               mem_r_ack_o,
    input  logic               mem_w_req_i,
    input  logic [ADDR_W-1:0]  mem_w_addr_i,
    input  logic [DATA_W-1:0]  mem_w_data_i,
    output logic               mem_w_ack_o,
    output logic               stall_o,
    output logic               ram_en_o,
    output logic               ram_we_o,
    output logic [ADDR_W-1:0]  ram_addr_o,
    output logic [DATA_W-1:0]  ram_wdata_o,
    input  logic [DATA_W-1:0]  ram_rdata_i
);

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_src;
    logic                r_ram_en;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic [DATA_W-1:0]   r_inst;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_inst_ack;
    logic                r_r_ack;
    logic                r_w_ack;

    logic                w_grant_write;
    logic                w_grant_read;
    logic                w_grant_src;
    logic [ADDR_W-1:0]   w_grant_addr;
    logic                w_enter_done;
    logic [ADDR_W-1:0]   w_inst_word;
    logic                w_unused_addr_bits;

    assign w_inst_word        = inst_addr_i[ADDR_W+1:2];
    assign w_unused_addr_bits = ^{inst_addr_i[IADDR_W-1:ADDR_W+2], inst_addr_i[1:0]};
    assign w_enter_done       = (r_state == S_WAIT) && (r_cnt == CNT_ZERO);

    // Next-state and grant decode; write beats data read beats fetch.
    always_comb begin
        w_next_state  = r_state;
        w_grant_write = 1'b0;
        w_grant_read  = 1'b0;
        w_grant_src   = SRC_INST;
        w_grant_addr  = r_ram_addr;
        case (r_state)
            S_IDLE: begin
                if (mem_w_req_i) begin
                    w_next_state  = S_WRITE;
                    w_grant_write = 1'b1;
                    w_grant_addr  = mem_w_addr_i;
                end else if (mem_r_req_i) begin
                    w_next_state  = S_READ;
                    w_grant_read  = 1'b1;
                    w_grant_src   = SRC_DATA;
                    w_grant_addr  = mem_r_addr_i;
                end else if (inst_req_i) begin
                    w_next_state  = S_READ;
                    w_grant_read  = 1'b1;
                    w_grant_src   = SRC_INST;
                    w_grant_addr  = w_inst_word;
                end else begin
                    w_next_state  = S_IDLE;
                end
            end
            S_WRITE: w_next_state = S_IDLE;
            S_READ:  w_next_state = S_WAIT;
            S_WAIT: begin
                if (r_cnt == CNT_ZERO) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // SRAM command, latency counter, return data and acks; the WAIT phase
    // spans RD_LAT cycles so capture lands on the first valid rdata cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= CNT_ZERO;
            r_src       <= SRC_INST;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= {ADDR_W{1'b0}};
            r_ram_wdata <= {DATA_W{1'b0}};
            r_inst      <= {DATA_W{1'b0}};
            r_rdata     <= {DATA_W{1'b0}};
            r_inst_ack  <= 1'b0;
            r_r_ack     <= 1'b0;
            r_w_ack     <= 1'b0;
        end else begin
            r_ram_en   <= w_grant_write | w_grant_read;
            r_ram_we   <= w_grant_write;
            r_w_ack    <= w_grant_write;
            r_inst_ack <= w_enter_done && (r_src == SRC_INST);
            r_r_ack    <= w_enter_done && (r_src == SRC_DATA);
            if (w_grant_write || w_grant_read) begin
                r_ram_addr <= w_grant_addr;
            end
            if (w_grant_write) begin
                r_ram_wdata <= mem_w_data_i;
            end
            if (w_grant_read) begin
                r_src <= w_grant_src;
            end
            if (r_state == S_READ) begin
                r_cnt <= CNT_LOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != CNT_ZERO)) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (w_enter_done) begin
                if (r_src == SRC_INST) begin
                    r_inst <= ram_rdata_i;
                end else begin
                    r_rdata <= ram_rdata_i;
                end
            end
        end
    end

    assign stall_o = (inst_req_i  & ~r_inst_ack)
                   | (mem_r_req_i & ~r_r_ack)
                   | (mem_w_req_i & ~r_w_ack);

    assign inst_o       = r_inst;
    assign inst_ack_o   = r_inst_ack;
    assign mem_r_data_o = r_rdata;
    assign mem_r_ack_o  = r_r_ack;
    assign mem_w_ack_o  = r_w_ack;
    assign ram_en_o     = r_ram_en;
    assign ram_we_o     = r_ram_we;
    assign ram_addr_o   = r_ram_addr;
    assign ram_wdata_o  = r_ram_wdata;

endmodule
